// File: rtl/h264_chroma_pkg.sv
// rtl/h264_chroma_pkg.sv - shared types and constants for the chroma feedback responder
// Purpose: FSM state enum, lane widths, block geometry and default feedback delay.
// Ports: none (package).
package h264_chroma_pkg;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_EMIT   = 2'd2
  } state_e;

  localparam int RES_W          = 9;
  localparam int PIX_W          = 8;
  localparam int LANES          = 4;
  localparam int FB_DELAY_DEF   = 4;
  localparam int WORDS_PER_BLK  = 4;
  localparam int BLKS_PER_PLANE = 4;

  localparam int DATA_W = LANES * RES_W;
  localparam int BASE_W = LANES * PIX_W;
  localparam int SLOT_W = DATA_W + BASE_W;

endpackage

// File: rtl/recon_clip4.sv
// rtl/recon_clip4.sv - four-lane reconstruction: base + residual clipped to 0..255
// Ports:
//   res_i  [35:0] four signed 9-bit residual lanes, lane0 in the low bits
//   base_i [31:0] four unsigned 8-bit prediction lanes, lane0 in the low bits
//   pix_o  [31:0] four reconstructed 8-bit lanes
module recon_clip4
  import h264_chroma_pkg::*;
(
  input  logic [DATA_W-1:0] res_i,
  input  logic [BASE_W-1:0] base_i,
  output logic [BASE_W-1:0] pix_o
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [RES_W:0] sum;

    // 10-bit signed sum covers -256..510, so no overflow is possible.
    assign sum = $signed({2'b00, base_i[l*PIX_W +: PIX_W]})
               + $signed({res_i[l*RES_W + RES_W - 1], res_i[l*RES_W +: RES_W]});

    // Sign bit set -> negative -> 0; otherwise bit 8 set means > 255 -> saturate.
    assign pix_o[l*PIX_W +: PIX_W] = sum[RES_W]  ? '0 :
                                     sum[PIX_W]  ? '1 : sum[PIX_W-1:0];
  end

endmodule

// File: rtl/chroma_fb_responder.sv
// rtl/chroma_fb_responder.sv - buffers one 4x4 chroma block and replays it as reconstructed feedback
// Ports:
//   CLK2      clock, rising edge        NRESET   sync active-low reset
//   STROBEO   input word valid          DATAO    4 x signed 9-bit residuals
//   BASEO     4 x 8-bit prediction      READYO   ready for a new block
//   FBSTROBE  feedback word valid       FEEDBO   4 x 8-bit reconstructed pixels
//   FBQUAD    block index in plane      FBCRCB   plane (0 Cb, 1 Cr)
//   MBDONE    pulse after 8th block     PROTO_ERR sticky strobe-while-busy flag
module chroma_fb_responder
  import h264_chroma_pkg::*;
#(
  parameter int FB_DELAY = FB_DELAY_DEF
) (
  input  logic              CLK2,
  input  logic              NRESET,
  input  logic              STROBEO,
  input  logic [DATA_W-1:0] DATAO,
  input  logic [BASE_W-1:0] BASEO,
  output logic              READYO,
  output logic              FBSTROBE,
  output logic [BASE_W-1:0] FEEDBO,
  output logic [1:0]        FBQUAD,
  output logic              FBCRCB,
  output logic              MBDONE,
  output logic              PROTO_ERR
);

  localparam logic [3:0] DLY_LAST  = 4'(FB_DELAY - 1);
  localparam logic [1:0] WORD_LAST = 2'(WORDS_PER_BLK - 1);
  localparam logic [1:0] QUAD_LAST = 2'(BLKS_PER_PLANE - 1);

  state_e            state_q, state_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [3:0]        dcnt_q, dcnt_d;
  logic [1:0]        quad_q, quad_d;
  logic              crcb_q, crcb_d;
  logic              mbdone_q, mbdone_d;
  logic              perr_q, perr_d;
  logic              wr_en;
  logic [SLOT_W-1:0] buf_q [WORDS_PER_BLK];
  logic [SLOT_W-1:0] rd_slot;
  logic [BASE_W-1:0] recon;

  // State register and datapath flops; reset wins over any strobe.
  always_ff @(posedge CLK2) begin
    if (!NRESET) begin
      state_q  <= ST_ACCEPT;
      wcnt_q   <= '0;
      dcnt_q   <= '0;
      quad_q   <= '0;
      crcb_q   <= 1'b0;
      mbdone_q <= 1'b0;
      perr_q   <= 1'b0;
      for (int i = 0; i < WORDS_PER_BLK; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      dcnt_q   <= dcnt_d;
      quad_q   <= quad_d;
      crcb_q   <= crcb_d;
      mbdone_q <= mbdone_d;
      perr_q   <= perr_d;
      if (wr_en) buf_q[wcnt_q] <= {DATAO, BASEO};
    end
  end

  // Next-state logic. wcnt doubles as the write pointer in ACCEPT and the
  // read pointer in EMIT; it is 0 on entry to both because it wraps after 4.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    dcnt_d   = dcnt_q;
    quad_d   = quad_q;
    crcb_d   = crcb_q;
    mbdone_d = 1'b0;
    perr_d   = perr_q;
    wr_en    = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        if (STROBEO) begin
          wr_en  = 1'b1;
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == WORD_LAST) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (STROBEO) perr_d = 1'b1;
        if (dcnt_q == DLY_LAST) begin
          dcnt_d  = '0;
          state_d = ST_EMIT;
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end
      ST_EMIT: begin
        if (STROBEO) perr_d = 1'b1;
        wcnt_d = wcnt_q + 2'd1;
        if (wcnt_q == WORD_LAST) begin
          state_d = ST_ACCEPT;
          quad_d  = quad_q + 2'd1;
          if (quad_q == QUAD_LAST) begin
            crcb_d   = ~crcb_q;
            mbdone_d = crcb_q;   // Cr plane finished -> macroblock complete
          end
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  assign rd_slot = buf_q[wcnt_q];

  recon_clip4 u_recon (
    .res_i  (rd_slot[SLOT_W-1 -: DATA_W]),
    .base_i (rd_slot[BASE_W-1:0]),
    .pix_o  (recon)
  );

  // Outputs are forced low combinationally while reset is held.
  always_comb begin
    READYO    = NRESET && (state_q == ST_ACCEPT);
    FBSTROBE  = NRESET && (state_q == ST_EMIT);
    FEEDBO    = FBSTROBE ? recon  : '0;
    FBQUAD    = FBSTROBE ? quad_q : '0;
    FBCRCB    = FBSTROBE && crcb_q;
    MBDONE    = NRESET && mbdone_q;
    PROTO_ERR = NRESET && perr_q;
  end

endmodule

// File: doc/chroma_fb_responder.md
CHROMA_FB_RESPONDER -- requirements
Module: chroma_fb_responder

Interface
REQ-001 SHALL have parameter FB_DELAY, default 4, legal range 1..15: cycles from last accepted word to first feedback word, minus one.
REQ-002 SHALL have port CLK2 input 1: the single clock; all state updates on rising edge.
REQ-003 SHALL have port NRESET input 1: reset, synchronous and active-low.
REQ-004 SHALL have port STROBEO input 1: predictor output word valid.
REQ-005 SHALL have port DATAO input 36: four signed 9-bit residual lanes; lane0 = [8:0], lane3 = [35:27].
REQ-006 SHALL have port BASEO input 32: four unsigned 8-bit prediction lanes; lane0 = [7:0].
REQ-007 SHALL have port READYO output 1: responder can accept a new 4x4 block.
REQ-008 SHALL have port FBSTROBE output 1: feedback word valid.
REQ-009 SHALL have port FEEDBO output 32: four reconstructed 8-bit lanes, same lane order as BASEO.
REQ-010 SHALL have port FBQUAD output 2 and port FBCRCB output 1: block index and chroma plane (0 = Cb, 1 = Cr) of the current feedback.
REQ-011 SHALL have port MBDONE output 1: one-cycle pulse after the 8th block of a macroblock.
REQ-012 SHALL have port PROTO_ERR output 1: sticky protocol-error flag.

Function
REQ-013 SHALL use three states: ACCEPT, WAIT and EMIT.
REQ-014 In ACCEPT:
- READYO = 1.
- Each STROBEO stores {DATAO, BASEO} into buffer slot wcnt, and wcnt increments (2-bit).
- Gaps between strobes are allowed.
REQ-015 On the 4th accepted word, SHALL go to WAIT; READYO = 0 from the next cycle; wcnt wraps to 0.
REQ-016 WAIT SHALL last exactly FB_DELAY cycles, then go to EMIT; first FBSTROBE is at cycle t+1+FB_DELAY, where t is the cycle of the 4th strobe.
REQ-017 EMIT SHALL last exactly 4 consecutive cycles with FBSTROBE = 1, emitting slots 0..3 in order; the cycle after, it returns to ACCEPT.
REQ-018 Each FEEDBO lane SHALL be clip(base + residual) in 10-bit signed arithmetic: result < 0 gives 0, result > 255 gives 255, otherwise the result.
REQ-019 During EMIT, FBQUAD and FBCRCB SHALL equal the block counters; they are 0 when FBSTROBE = 0.
REQ-020 After EMIT, quad SHALL increment (2-bit wrap); on the 3->0 wrap, crcb SHALL toggle.
REQ-021 On the Cr quad-3 wrap, MBDONE SHALL pulse in the cycle after the last FBSTROBE, and crcb returns to 0.
REQ-022 STROBEO while READYO = 0 SHALL be ignored (buffer unchanged) and SHALL set PROTO_ERR, which stays set until reset.
REQ-023 FEEDBO SHALL be 0 whenever FBSTROBE = 0.

Reset
REQ-024 NRESET = 0 at a rising edge SHALL, from any state including mid-block, force the following:
- state ACCEPT;
- wcnt, quad, crcb and the WAIT counter to 0;
- buffer contents discarded.
REQ-025 While in reset SHALL drive READYO, FBSTROBE, FEEDBO, FBQUAD, FBCRCB, MBDONE and PROTO_ERR all to 0; READYO = 1 in the first cycle after release.
REQ-026 SHALL ignore STROBEO during any cycle in which NRESET = 0.

Structure
REQ-027 Package h264_chroma_pkg SHALL hold:
- the state enum;
- lane widths 9/8;
- the FB_DELAY default;
- the words-per-block (4) and blocks-per-plane (4) constants.
REQ-028 The 4-lane add-and-clip SHALL be a combinational sub-module recon_clip4, instantiated once on the EMIT read path.
REQ-029 Buffer SHALL be 4 x 68 bits of flops; no memory macro.

Verification
REQ-030 Four back-to-back strobes with BASEO = 0x80808080 and DATAO lanes = +5 -> READYO low from cycle t+1; FBSTROBE cycles t+5..t+8 with FB_DELAY = 4; FEEDBO = 0x85858585; FBQUAD = 0, FBCRCB = 0.
REQ-031 Clip lanes: base 0xFA, residual +20 -> 0xFF; base 0x03, residual -10 -> 0x00; base 0x10, residual -16 -> 0x00.
REQ-032 Eight blocks with random gaps -> FBQUAD sequence 0,1,2,3,0,1,2,3; FBCRCB 0 then 1; single MBDONE pulse after the 8th block's last FBSTROBE.
REQ-033 STROBEO asserted during WAIT -> PROTO_ERR = 1; emitted feedback matches the original block unchanged.
REQ-034 NRESET low during EMIT word 2 -> the next cycle all outputs are 0; after release, READYO = 1 and the next block reports FBQUAD = 0.
REQ-035 FB_DELAY = 1 and FB_DELAY = 15 -> first FBSTROBE at t+2 and t+16 respectively.
